// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment scan driver.
// Each digit stays lit for SCAN_DIV clocks. New values are taken from the CPU
// at any time but only reach the display at a frame boundary, so a frame is
// never torn. Also handles per-digit decimal points, a live blank mask and
// leading-zero suppression. Output word: {anode[N-1:0], dp, g,f,e,d,c,b,a}.
module seg_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 10000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS+7:0]   digi,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // XOR masks that turn active-high "on" patterns into pin levels; they are
    // also the all-dark pin pattern.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [7:0]            SEG_OFF   = {8{SEG_ACTIVE_LOW}};

    // Hex nibble to active-high gfedcba pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h00;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan position
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             wrap;

    // Displayed frame and the staged update waiting for the next frame
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    disp_lz;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_lz;
    logic                    pend_flag;

    // Combinational decode of the current digit (feeds the output register)
    logic [NUM_DIGITS-1:0] sel_p0;
    logic [NUM_DIGITS-1:0] lead_dark_p0;
    logic [NUM_DIGITS-1:0] anode_p0;
    logic [3:0]            nib_p0;
    logic                  dp_p0;
    logic                  dark_p0;
    logic                  lz_run_p0;
    logic [7:0]            seg_p0;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Prescaler and digit index; index advances once per SCAN_DIV clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Value staging: loads park in the pending copy, which is promoted to the
    // display only on the frame wrap. A load landing on the wrap itself goes
    // straight to the display and discards any older pending copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_value <= '0;
            disp_dp    <= '0;
            disp_lz    <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_flag  <= 1'b0;
        end else if (load && wrap) begin
            disp_value <= value;
            disp_dp    <= dp;
            disp_lz    <= lz_en;
            pend_flag  <= 1'b0;
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pend_lz    <= lz_en;
            pend_flag  <= 1'b1;
        end else if (wrap && pend_flag) begin
            disp_value <= pend_value;
            disp_dp    <= pend_dp;
            disp_lz    <= pend_lz;
            pend_flag  <= 1'b0;
        end
    end

    // Stage p0: select the current digit, work out whether it is dark and
    // build the active-high anode/segment pattern.
    always_comb begin
        sel_p0       = '0;
        lead_dark_p0 = '0;
        nib_p0       = 4'h0;
        dp_p0        = 1'b0;
        lz_run_p0    = disp_lz;

        // Walk from the most significant digit down; a digit is a leading
        // zero while every nibble seen so far (itself included) is zero.
        // Digit 0 always stays visible so a zero value still shows "0".
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run_p0 = lz_run_p0 && (disp_value[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lead_dark_p0[i] = lz_run_p0;
            end
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_p0[i] = 1'b1;
                nib_p0    = disp_value[4*i +: 4];
                dp_p0     = disp_dp[i];
            end
        end

        dark_p0  = |(sel_p0 & (blank_mask | lead_dark_p0));
        anode_p0 = dark_p0 ? '0 : sel_p0;
        seg_p0   = dark_p0 ? 8'h00 : {dp_p0, hex_to_seg(nib_p0)};
    end

    // Stage p1: registered pin levels and the frame-start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digi       <= {ANODE_OFF, SEG_OFF};
            frame_done <= 1'b0;
        end else begin
            digi       <= {anode_p0 ^ ANODE_OFF, seg_p0 ^ SEG_OFF};
            frame_done <= wrap;
        end
    end

endmodule
